// File: rtl/run_code_tx.sv
// Run-length code transmitter: drives frames of 0, N ones, 0 on line x.
// A one-entry hold register lets consecutive frames share a 0 bit.
module run_code_tx #(
    parameter int LONG_RUN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] code,
    output logic       in_ready,
    output logic       x,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ONES  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [3:0] LR = 4'(LONG_RUN);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       hold_v, hold_v_n;
    logic [1:0] hold_code, hold_code_n;
    logic       accept;

    function automatic logic [3:0] load_n(input logic [1:0] c);
        case (c)
            2'b01:   return 4'd1;
            2'b10:   return 4'd2;
            2'b11:   return LR;
            default: return 4'd0;
        endcase
    endfunction

    assign accept = in_valid & ~hold_v & (code != 2'b00);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold_v_n    = hold_v;
        hold_code_n = hold_code;
        if (accept) begin
            hold_v_n    = 1'b1;
            hold_code_n = code;
        end
        case (state)
            IDLE: begin
                if (hold_v) begin
                    state_n  = START;
                    hold_v_n = 1'b0;
                    cnt_n    = load_n(hold_code);
                end
            end
            START: state_n = ONES;
            ONES: begin
                if (cnt > 4'd1) cnt_n = cnt - 4'd1;
                else            state_n = STOP;
            end
            STOP: begin
                // the STOP zero doubles as the next frame's start bit
                if (hold_v) begin
                    state_n  = ONES;
                    hold_v_n = 1'b0;
                    cnt_n    = load_n(hold_code);
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            hold_v     <= 1'b0;
            hold_code  <= 2'b00;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hold_v     <= hold_v_n;
            hold_code  <= hold_code_n;
            frame_done <= (state_n == STOP);
        end
    end

    assign in_ready = ~hold_v;
    assign x        = (state == IDLE) || (state == ONES);
    assign busy     = (state != IDLE);

endmodule
